rf_envelope_shaper: RTL and testbench
=====================================

# rf_envelope_shaper

Downstream consumer of the interferometer pulse sequencer's `rf` gate. Converts each rectangular gate (π/2, π, π/2) into a trapezoidal DDS amplitude word with programmable linear ramps, and drives the DDS output enable. Tracks completed pulses per interferometer shot and flags truncated or surplus pulses. Sits between the sequencer and the DDS amplitude register.

## Interface
- `AMP_W`, 14: amplitude word width.
- `AMP_MAX`, 16383: plateau amplitude; must be ≤ 2^AMP_W − 1.
- `PULSES_PER_SEQ`, 3: pulses in one shot (π/2, π, π/2).

- `clk` input 1: single system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rf` input 1: pulse gate from the sequencer, synchronous to `clk`.
- `amp_step` input AMP_W: ramp increment per cycle; sampled on pulse start.
- `clear` input 1: one-cycle strobe; starts a new shot by zeroing the pulse count and `seq_done`.
- `amp_out` output AMP_W: DDS amplitude word.
- `rf_en` output 1: DDS output enable; high in every state except IDLE.
- `busy` output 1: same as `rf_en`; kept separate for the sequencer's status bus.
- `pulse_idx` output 2: number of completed pulses in the current shot.
- `seq_done` output 1: sticky; set when `pulse_idx` reaches PULSES_PER_SEQ.
- `gate_err` output 1: one-cycle strobe on a truncated or surplus pulse.

## Operation
- `rf_q` holds `rf` delayed by one cycle. A rise is `rf & ~rf_q`.
- **States:** IDLE, RAMP_UP, HOLD, RAMP_DOWN. `step_q` is latched from `amp_step` on the IDLE→RAMP_UP transition.
- **IDLE:**
  - `amp_out` = 0.
  - On a rise of `rf` → RAMP_UP, with `amp_out` ← min(`amp_step`, AMP_MAX).
- **RAMP_UP:**
  - `amp_out` ← min(`amp_out` + `step_q`, AMP_MAX) each cycle.
  - The sum is computed in AMP_W+1 bits; it saturates and never wraps.
  - On reaching AMP_MAX → HOLD.
- **HOLD:**
  - `amp_out` = AMP_MAX while `rf` = 1.
  - When `rf` = 0 → RAMP_DOWN.
- **RAMP_DOWN:**
  - `amp_out` ← max(`amp_out` − `step_q`, 0). The subtraction floors at 0 and never underflows.
  - On reaching 0 → IDLE and the pulse is counted complete.
- **`step_q` = 0:** ramps are disabled.
  - IDLE→HOLD directly, with `amp_out` = AMP_MAX.
  - HOLD→IDLE directly, with `amp_out` = 0.
- **`rf` falls during RAMP_UP:** → RAMP_DOWN from the current amplitude, and `gate_err` pulses.
- **`rf` rises during RAMP_DOWN:** → RAMP_UP from the current amplitude. This is the same pulse; nothing is counted and there is no error.
- **`clear` together with a pulse completion:** `clear` wins; `pulse_idx` = 0 and `seq_done` = 0.
- **`rst` mid-pulse:** all registers return to reset values immediately, including `amp_out` = 0. No ramp-down is performed.

## Timing
- **Reset values:**
  - `amp_out` = 0, `rf_en` = 0, `busy` = 0.
  - `pulse_idx` = 0, `seq_done` = 0, `gate_err` = 0.
  - State = IDLE, `rf_q` = 0, `step_q` = 0.
- **Start latency:** `rf` first high at edge k → `amp_out` = step and `rf_en` = 1 after edge k.
- **Ramp length:** ceil(AMP_MAX / step) cycles, both up and down.
- **Stop latency:** `rf` first low at edge k in HOLD → first decremented value after edge k.
- **Pulse completion:** `pulse_idx` increments on the same edge the state returns to IDLE. `seq_done` rises on that edge if the new count equals PULSES_PER_SEQ.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`RF_ENV_PULSE_COUNT_EN` defined:**
  - Pulse counter, `seq_done` and surplus detection are built.
  - Once `seq_done` = 1, each further pulse is still shaped normally.
  - Each surplus pulse raises `gate_err` for one cycle on its start edge; `pulse_idx` stays saturated at PULSES_PER_SEQ.
- **`RF_ENV_PULSE_COUNT_EN` undefined:**
  - `pulse_idx` and `seq_done` are tied to 0 and `clear` is ignored.
  - `gate_err` reports truncation only.

## Test plan
- **Ramp up / down:** AMP_MAX = 16383, `amp_step` = 4096, `rf` high 10 cycles → `amp_out` 4096, 8192, 12288, 16383, hold, then 12287, 8191, 4095, 0; `rf_en` drops with `amp_out` = 0; `pulse_idx` = 1.
- **Full shot:** sequencer-style gates of 10, 20, 10 cycles separated by 20-cycle gaps, `amp_step` = 8192 → three trapezoids; `pulse_idx` = 3 and `seq_done` = 1 after the third reaches 0; `gate_err` never asserted.
- **Truncation:** `amp_step` = 1024, `rf` high 3 cycles → peak 3072, then ramps down to 0; one `gate_err` strobe on the fall; `pulse_idx` = 1.
- **Retrigger and step 0:** `rf` re-rises at `amp_out` = 8191 during ramp-down → ramps up from 8191 without a count. `amp_step` = 0 → square pulse of 16383 with 1-cycle latency on both edges.
- **Surplus / clear (macro defined):** fourth pulse after `seq_done` → `gate_err` strobe, `pulse_idx` stays 3. Then `clear` → `pulse_idx` = 0, `seq_done` = 0.
- **Reset mid-HOLD:** `rst` asserted for 1 cycle at `amp_out` = 16383 → after that edge all outputs are 0 and state is IDLE. A later `rf` rise restarts normally.

Source files
------------

// File: rtl/rf_envelope_shaper.sv
// Shapes rectangular rf gates into trapezoidal DDS amplitude words with linear ramps.
// Define RF_ENV_PULSE_COUNT_EN to build the per-shot pulse counter, seq_done and surplus detection.
module rf_envelope_shaper #(
  parameter int unsigned AMP_W          = 14,
  parameter int unsigned AMP_MAX        = 16383,
  parameter int unsigned PULSES_PER_SEQ = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rf,
  input  logic [AMP_W-1:0] amp_step,
  input  logic             clear,
  output logic [AMP_W-1:0] amp_out,
  output logic             rf_en,
  output logic             busy,
  output logic [1:0]       pulse_idx,
  output logic             seq_done,
  output logic             gate_err
);

  localparam logic [AMP_W-1:0] AmpMax = AMP_W'(AMP_MAX);

  typedef enum logic [1:0] {StIdle, StRampUp, StHold, StRampDown} state_e;

  state_e           state_q, state_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic [AMP_W-1:0] step_q, step_d;
  logic             rf_q;
  logic             gate_err_q;

  logic             rise;
  logic             start;
  logic             trunc;
  logic             complete;
  logic             surplus;

  logic [AMP_W:0]   sum_up;
  logic [AMP_W-1:0] amp_up, amp_dn, amp_start;

  assign rise = rf & ~rf_q;

  // Saturating ramp arithmetic; the extra sum bit keeps the up-ramp from wrapping.
  always_comb begin
    sum_up    = {1'b0, amp_q} + {1'b0, step_q};
    amp_up    = (sum_up >= {1'b0, AmpMax}) ? AmpMax : sum_up[AMP_W-1:0];
    amp_dn    = (amp_q > step_q) ? (amp_q - step_q) : '0;
    amp_start = (amp_step >= AmpMax) ? AmpMax : amp_step;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      amp_q      <= '0;
      step_q     <= '0;
      rf_q       <= 1'b0;
      gate_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      amp_q      <= amp_d;
      step_q     <= step_d;
      rf_q       <= rf;
      gate_err_q <= trunc | surplus;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    amp_d    = amp_q;
    step_d   = step_q;
    start    = 1'b0;
    trunc    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        amp_d = '0;
        if (rise) begin
          start  = 1'b1;
          step_d = amp_step;
          if (amp_step == '0) begin
            amp_d   = AmpMax;
            state_d = StHold;
          end else begin
            amp_d   = amp_start;
            state_d = (amp_start == AmpMax) ? StHold : StRampUp;
          end
        end
      end
      StRampUp: begin
        if (!rf) begin
          trunc = 1'b1;
          amp_d = amp_dn;
          if (amp_dn == '0) begin
            state_d  = StIdle;
            complete = 1'b1;
          end else begin
            state_d = StRampDown;
          end
        end else begin
          amp_d = amp_up;
          if (amp_up == AmpMax) state_d = StHold;
        end
      end
      StHold: begin
        amp_d = AmpMax;
        if (!rf) begin
          if (step_q == '0) begin
            // Ramps disabled: square pulse edge.
            amp_d    = '0;
            state_d  = StIdle;
            complete = 1'b1;
          end else begin
            amp_d   = amp_dn;
            state_d = (amp_dn == '0) ? StIdle : StRampDown;
            complete = (amp_dn == '0);
          end
        end
      end
      StRampDown: begin
        if (rise) begin
          // Re-rise mid ramp-down continues the same pulse.
          amp_d   = amp_up;
          state_d = (amp_up == AmpMax) ? StHold : StRampUp;
        end else begin
          amp_d = amp_dn;
          if (amp_dn == '0) begin
            state_d  = StIdle;
            complete = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        amp_d   = '0;
      end
    endcase
  end

  // Outputs, all derived from registers
  always_comb begin
    amp_out  = amp_q;
    rf_en    = (state_q != StIdle);
    busy     = (state_q != StIdle);
    gate_err = gate_err_q;
  end

`ifdef RF_ENV_PULSE_COUNT_EN
  localparam logic [1:0] PulsesMax = 2'(PULSES_PER_SEQ);

  logic [1:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clear) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (complete && (cnt_q != PulsesMax)) begin
      cnt_d  = cnt_q + 2'd1;
      done_d = (cnt_d == PulsesMax);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign surplus   = start & done_q & ~clear;
  assign pulse_idx = cnt_q;
  assign seq_done  = done_q;
`else
  logic unused_ctl;
  assign unused_ctl = clear ^ start ^ complete;
  assign surplus    = 1'b0;
  assign pulse_idx  = 2'd0;
  assign seq_done   = 1'b0;
`endif

endmodule

// File: tb/tb_rf_envelope_shaper.sv
// Directed self-checking bench for rf_envelope_shaper; counter checks follow RF_ENV_PULSE_COUNT_EN.
module tb_rf_envelope_shaper;

`ifdef RF_ENV_PULSE_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rf = 1'b0;
  logic [13:0] amp_step = '0;
  logic        clear = 1'b0;
  logic [13:0] amp_out;
  logic        rf_en;
  logic        busy;
  logic [1:0]  pulse_idx;
  logic        seq_done;
  logic        gate_err;

  int vectors = 0;
  int miscompares = 0;

  rf_envelope_shaper dut (
    .clk       (clk),
    .rst       (rst),
    .rf        (rf),
    .amp_step  (amp_step),
    .clear     (clear),
    .amp_out   (amp_out),
    .rf_en     (rf_en),
    .busy      (busy),
    .pulse_idx (pulse_idx),
    .seq_done  (seq_done),
    .gate_err  (gate_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rf = 1'b0; clear = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rf = 1'b0; clear = 1'b0; amp_step = 14'd100;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (amp_out !== 14'd0) begin miscompares++; $display("FAIL reset amp_out got %0d expected 0", amp_out); end
    vectors++;
    if (rf_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset rf_en/busy got %b/%b expected 0/0", rf_en, busy);
    end
    vectors++;
    if (pulse_idx !== 2'd0 || seq_done !== 1'b0) begin
      miscompares++; $display("FAIL reset count got %0d/%b expected 0/0", pulse_idx, seq_done);
    end
    vectors++;
    if (gate_err !== 1'b0) begin miscompares++; $display("FAIL reset gate_err got %b expected 0", gate_err); end
  endtask

  task automatic test_ramp();
    int exp_amp [14];
    exp_amp = '{4096, 8192, 12288, 16383, 16383, 16383, 16383, 16383, 16383, 16383,
                12287, 8191, 4095, 0};
    do_reset();
    amp_step = 14'd4096;
    for (int i = 0; i < 14; i++) begin
      rf = (i < 10);
      tick();
      vectors++;
      if (amp_out !== 14'(exp_amp[i])) begin
        miscompares++; $display("FAIL ramp amp[%0d] got %0d expected %0d", i, amp_out, exp_amp[i]);
      end
      vectors++;
      if (rf_en !== (i < 13) || busy !== (i < 13)) begin
        miscompares++; $display("FAIL ramp rf_en[%0d] got %b/%b expected %b", i, rf_en, busy, (i < 13));
      end
      vectors++;
      if (gate_err !== 1'b0) begin
        miscompares++; $display("FAIL ramp gate_err[%0d] got %b expected 0", i, gate_err);
      end
    end
    vectors++;
    if (pulse_idx !== 2'(CountEn ? 1 : 0)) begin
      miscompares++; $display("FAIL ramp pulse_idx got %0d expected %0d", pulse_idx, CountEn ? 1 : 0);
    end
  endtask

  task automatic test_full_shot();
    int hi [3];
    int exp_amp;
    hi = '{10, 20, 10};
    do_reset();
    amp_step = 14'd8192;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < hi[p] + 20; i++) begin
        rf = (i < hi[p]);
        tick();
        if (i == 0) exp_amp = 8192;
        else if (i < hi[p]) exp_amp = 16383;
        else if (i == hi[p]) exp_amp = 8191;
        else exp_amp = 0;
        vectors++;
        if (amp_out !== 14'(exp_amp)) begin
          miscompares++;
          $display("FAIL shot p%0d amp[%0d] got %0d expected %0d", p, i, amp_out, exp_amp);
        end
        vectors++;
        if (gate_err !== 1'b0) begin
          miscompares++; $display("FAIL shot p%0d gate_err[%0d] got 1 expected 0", p, i);
        end
        if (p == 2 && i == hi[p]) begin
          vectors++;
          if (seq_done !== 1'b0) begin
            miscompares++; $display("FAIL shot seq_done early got %b expected 0", seq_done);
          end
        end
        if (p == 2 && i == hi[p] + 1) begin
          vectors++;
          if (seq_done !== CountEn) begin
            miscompares++; $display("FAIL shot seq_done edge got %b expected %b", seq_done, CountEn);
          end
        end
      end
      vectors++;
      if (pulse_idx !== 2'(CountEn ? p + 1 : 0)) begin
        miscompares++;
        $display("FAIL shot pulse_idx p%0d got %0d expected %0d", p, pulse_idx, CountEn ? p + 1 : 0);
      end
      vectors++;
      if (seq_done !== (CountEn && p == 2)) begin
        miscompares++;
        $display("FAIL shot seq_done p%0d got %b expected %b", p, seq_done, (CountEn && p == 2));
      end
    end
  endtask

  task automatic test_truncation();
    int exp_amp [6];
    bit exp_err [6];
    exp_amp = '{1024, 2048, 3072, 2048, 1024, 0};
    exp_err = '{0, 0, 0, 1, 0, 0};
    do_reset();
    amp_step = 14'd1024;
    for (int i = 0; i < 6; i++) begin
      rf = (i < 3);
      tick();
      vectors++;
      if (amp_out !== 14'(exp_amp[i])) begin
        miscompares++; $display("FAIL trunc amp[%0d] got %0d expected %0d", i, amp_out, exp_amp[i]);
      end
      vectors++;
      if (gate_err !== exp_err[i]) begin
        miscompares++; $display("FAIL trunc gate_err[%0d] got %b expected %b", i, gate_err, exp_err[i]);
      end
      vectors++;
      if (rf_en !== (i < 5)) begin
        miscompares++; $display("FAIL trunc rf_en[%0d] got %b expected %b", i, rf_en, (i < 5));
      end
    end
    vectors++;
    if (pulse_idx !== 2'(CountEn ? 1 : 0)) begin
      miscompares++; $display("FAIL trunc pulse_idx got %0d expected %0d", pulse_idx, CountEn ? 1 : 0);
    end
  endtask

  task automatic test_retrigger_step0();
    bit rf_pat [14];
    int exp_amp [14];
    bit sq_rf [5];
    int sq_amp [5];
    rf_pat  = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    exp_amp = '{4096, 8192, 12288, 16383, 16383, 12287, 8191, 12287, 16383, 16383,
                12287, 8191, 4095, 0};
    do_reset();
    amp_step = 14'd4096;
    for (int i = 0; i < 14; i++) begin
      rf = rf_pat[i];
      tick();
      vectors++;
      if (amp_out !== 14'(exp_amp[i])) begin
        miscompares++; $display("FAIL retrig amp[%0d] got %0d expected %0d", i, amp_out, exp_amp[i]);
      end
      vectors++;
      if (gate_err !== 1'b0) begin
        miscompares++; $display("FAIL retrig gate_err[%0d] got 1 expected 0", i);
      end
      if (i == 7) begin
        vectors++;
        if (pulse_idx !== 2'd0 || rf_en !== 1'b1) begin
          miscompares++;
          $display("FAIL retrig mid pulse_idx/rf_en got %0d/%b expected 0/1", pulse_idx, rf_en);
        end
      end
    end
    vectors++;
    if (pulse_idx !== 2'(CountEn ? 1 : 0)) begin
      miscompares++; $display("FAIL retrig pulse_idx got %0d expected %0d", pulse_idx, CountEn ? 1 : 0);
    end
    sq_rf  = '{1, 1, 1, 0, 0};
    sq_amp = '{16383, 16383, 16383, 0, 0};
    amp_step = 14'd0;
    for (int i = 0; i < 5; i++) begin
      rf = sq_rf[i];
      tick();
      vectors++;
      if (amp_out !== 14'(sq_amp[i])) begin
        miscompares++; $display("FAIL step0 amp[%0d] got %0d expected %0d", i, amp_out, sq_amp[i]);
      end
      vectors++;
      if (rf_en !== (i < 3)) begin
        miscompares++; $display("FAIL step0 rf_en[%0d] got %b expected %b", i, rf_en, (i < 3));
      end
    end
    vectors++;
    if (pulse_idx !== 2'(CountEn ? 2 : 0)) begin
      miscompares++; $display("FAIL step0 pulse_idx got %0d expected %0d", pulse_idx, CountEn ? 2 : 0);
    end
  endtask

  task automatic test_surplus_clear();
    do_reset();
    amp_step = 14'd0;
    for (int p = 0; p < 3; p++) begin
      rf = 1'b1; tick();
      rf = 1'b0; tick();
    end
    vectors++;
    if (pulse_idx !== 2'(CountEn ? 3 : 0) || seq_done !== CountEn) begin
      miscompares++;
      $display("FAIL surplus pre got %0d/%b expected %0d/%b", pulse_idx, seq_done, CountEn ? 3 : 0, CountEn);
    end
    rf = 1'b1; tick();
    vectors++;
    if (amp_out !== 14'd16383) begin
      miscompares++; $display("FAIL surplus amp got %0d expected 16383", amp_out);
    end
    vectors++;
    if (gate_err !== CountEn) begin
      miscompares++; $display("FAIL surplus gate_err got %b expected %b", gate_err, CountEn);
    end
    rf = 1'b0; tick();
    vectors++;
    if (gate_err !== 1'b0 || amp_out !== 14'd0) begin
      miscompares++; $display("FAIL surplus after got %b/%0d expected 0/0", gate_err, amp_out);
    end
    vectors++;
    if (pulse_idx !== 2'(CountEn ? 3 : 0) || seq_done !== CountEn) begin
      miscompares++;
      $display("FAIL surplus sat got %0d/%b expected %0d/%b", pulse_idx, seq_done, CountEn ? 3 : 0, CountEn);
    end
    clear = 1'b1; tick();
    clear = 1'b0;
    vectors++;
    if (pulse_idx !== 2'd0 || seq_done !== 1'b0) begin
      miscompares++; $display("FAIL clear got %0d/%b expected 0/0", pulse_idx, seq_done);
    end
    // Completion and clear on the same edge: clear wins.
    rf = 1'b1; tick();
    rf = 1'b0; clear = 1'b1; tick();
    clear = 1'b0;
    vectors++;
    if (pulse_idx !== 2'd0 || seq_done !== 1'b0) begin
      miscompares++; $display("FAIL clear+complete got %0d/%b expected 0/0", pulse_idx, seq_done);
    end
    rf = 1'b1; tick();
    rf = 1'b0; tick();
    vectors++;
    if (pulse_idx !== 2'(CountEn ? 1 : 0)) begin
      miscompares++; $display("FAIL post-clear pulse_idx got %0d expected %0d", pulse_idx, CountEn ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    amp_step = 14'd0;
    rf = 1'b1; tick();
    rf = 1'b0; tick();
    amp_step = 14'd4096;
    rf = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (amp_out !== 14'd16383) begin
      miscompares++; $display("FAIL rsthold pre amp got %0d expected 16383", amp_out);
    end
    rst = 1'b1; tick();
    rst = 1'b0;
    vectors++;
    if (amp_out !== 14'd0 || rf_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rsthold amp/rf_en/busy got %0d/%b/%b expected 0/0/0", amp_out, rf_en, busy);
    end
    vectors++;
    if (pulse_idx !== 2'd0 || seq_done !== 1'b0 || gate_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rsthold count/err got %0d/%b/%b expected 0/0/0", pulse_idx, seq_done, gate_err);
    end
    rf = 1'b0; tick(); tick();
    vectors++;
    if (amp_out !== 14'd0 || rf_en !== 1'b0) begin
      miscompares++; $display("FAIL rsthold idle got %0d/%b expected 0/0", amp_out, rf_en);
    end
    rf = 1'b1; tick();
    vectors++;
    if (amp_out !== 14'd4096 || rf_en !== 1'b1) begin
      miscompares++; $display("FAIL rsthold restart got %0d/%b expected 4096/1", amp_out, rf_en);
    end
    tick();
    rf = 1'b0; tick();
    vectors++;
    if (amp_out !== 14'd4096) begin
      miscompares++; $display("FAIL rsthold trunc amp got %0d expected 4096", amp_out);
    end
    tick();
    vectors++;
    if (amp_out !== 14'd0 || rf_en !== 1'b0 || pulse_idx !== 2'(CountEn ? 1 : 0)) begin
      miscompares++;
      $display("FAIL rsthold end got %0d/%b/%0d expected 0/0/%0d", amp_out, rf_en, pulse_idx, CountEn ? 1 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of tests");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp();
    test_full_shot();
    test_truncation();
    test_retrigger_step0();
    test_surplus_clear();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
